// File: rtl/bus_pkg.sv
// Shared bus definitions: ID field width, broadcast ID, destination extraction
// and the per-packet receive classification.
package bus_pkg;

    localparam int ID_W      = 8;
    localparam int PKT_MAX_W = 64;
    localparam logic [ID_W-1:0] BCAST_ID = 8'hFF;

    typedef enum logic [1:0] {
        RX_ACCEPT,
        RX_DROP,
        RX_FILT
    } rx_class_e;

    // The destination ID is the top ID_W bits of a pkt_w-bit packet.
    function automatic logic [ID_W-1:0] dst_of(input logic [PKT_MAX_W-1:0] pkt,
                                               input int unsigned pkt_w);
        return ID_W'(pkt >> (pkt_w - ID_W));
    endfunction

endpackage

// File: rtl/bus_rx_endpoint_sync_fifo.sv
// First-word fall-through synchronous FIFO with one-extra-bit pointers;
// the head is masked to zero while the FIFO is empty.
module sync_fifo #(
    parameter int width = 16,
    parameter int depth = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [width-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [width-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(depth):0]   level
);

    localparam int AW = $clog2(depth);

    logic [width-1:0] mem_q [depth];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             wr_ok;
    logic             rd_ok;

    assign level = wr_ptr_q - rd_ptr_q;
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (level == (AW+1)'(depth));

    // A pop on a full FIFO frees the slot the same-edge write lands in.
    assign rd_ok = rd_en && !empty;
    assign wr_ok = wr_en && (!full || rd_ok);

    assign rd_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (rd_ok) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/bus_rx_endpoint.sv
// Bus receive endpoint: destination-ID filter, per-packet classification,
// saturating statistics counters and a FWFT buffer toward the local consumer.
module bus_rx_endpoint
    import bus_pkg::*;
#(
    parameter int              pckg_sz   = 16,
    parameter int              depth     = 8,
    parameter logic [ID_W-1:0] id        = '0,
    parameter logic [ID_W-1:0] broadcast = BCAST_ID,
    parameter int              cnt_w     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [pckg_sz-1:0]       D_push,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [pckg_sz-1:0]       rd_data,
    output logic                     full,
    output logic [$clog2(depth):0]   level,
    output logic [cnt_w-1:0]         rx_cnt,
    output logic [cnt_w-1:0]         drop_cnt,
    output logic [cnt_w-1:0]         filt_cnt
);

    typedef enum logic {ST_IDLE, ST_CLASSIFY} rx_state_e;

    rx_state_e         state_q;
    rx_class_e         cls_q;
    rx_class_e         cls_d;
    logic [ID_W-1:0]   dst;
    logic              match;
    logic              pop;
    logic              accept;
    logic              empty;
    logic [cnt_w-1:0]  rx_cnt_q;
    logic [cnt_w-1:0]  drop_cnt_q;
    logic [cnt_w-1:0]  filt_cnt_q;

    assign dst    = dst_of(PKT_MAX_W'(D_push), pckg_sz);
    assign match  = (dst == id) || (dst == broadcast);
    assign pop    = rd_valid && rd_ready;
    assign accept = push && match && (!full || pop);

    always_comb begin
        cls_d = RX_FILT;
        if (match) cls_d = accept ? RX_ACCEPT : RX_DROP;
    end

    sync_fifo #(
        .width (pckg_sz),
        .depth (depth)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (accept),
        .wr_data (D_push),
        .rd_en   (pop),
        .rd_data (rd_data),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    assign rd_valid = !empty;

    // The class is registered on the push edge and applied to the counters one edge later.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cls_q      <= RX_ACCEPT;
            rx_cnt_q   <= '0;
            drop_cnt_q <= '0;
            filt_cnt_q <= '0;
        end else begin
            state_q <= push ? ST_CLASSIFY : ST_IDLE;
            cls_q   <= cls_d;
            if (state_q == ST_CLASSIFY) begin
                case (cls_q)
                    RX_ACCEPT: if (rx_cnt_q   != '1) rx_cnt_q   <= rx_cnt_q   + cnt_w'(1);
                    RX_DROP:   if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + cnt_w'(1);
                    default:   if (filt_cnt_q != '1) filt_cnt_q <= filt_cnt_q + cnt_w'(1);
                endcase
            end
        end
    end

    assign rx_cnt   = rx_cnt_q;
    assign drop_cnt = drop_cnt_q;
    assign filt_cnt = filt_cnt_q;

endmodule

// File: tb/tb_bus_rx_endpoint.sv
// Directed bench for bus_rx_endpoint (id=3, depth=8, 4-bit counters to reach saturation).
module tb_bus_rx_endpoint;

    logic        clk = 1'b0;
    logic        reset;
    logic        push;
    logic [15:0] D_push;
    logic        rd_valid;
    logic        rd_ready;
    logic [15:0] rd_data;
    logic        full;
    logic [3:0]  level;
    logic [3:0]  rx_cnt;
    logic [3:0]  drop_cnt;
    logic [3:0]  filt_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bus_rx_endpoint #(
        .pckg_sz   (16),
        .depth     (8),
        .id        (8'h03),
        .broadcast (8'hFF),
        .cnt_w     (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .D_push   (D_push),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .full     (full),
        .level    (level),
        .rx_cnt   (rx_cnt),
        .drop_cnt (drop_cnt),
        .filt_cnt (filt_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-14s observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        logic [15:0] exp_q [$];
        logic [15:0] want;
        int          rcv;

        // Reset held two cycles while the bus pushes a matching packet.
        reset = 1'b1; push = 1'b1; D_push = 16'h03AB; rd_ready = 1'b0;
        tick(); tick();
        chk("rst_valid", 32'(rd_valid), 0);
        chk("rst_data",  32'(rd_data),  0);
        chk("rst_level", 32'(level),    0);
        chk("rst_full",  32'(full),     0);
        chk("rst_rx",    32'(rx_cnt),   0);
        chk("rst_drop",  32'(drop_cnt), 0);
        chk("rst_filt",  32'(filt_cnt), 0);
        reset = 1'b0; push = 1'b0;
        tick();
        chk("idle_level", 32'(level), 0);

        // Own ID, broadcast, foreign ID.
        push = 1'b1; D_push = 16'h03AB; tick();
        chk("lat_valid", 32'(rd_valid), 1);
        chk("lat_data",  32'(rd_data),  32'h03AB);
        D_push = 16'hFF12; tick();
        D_push = 16'h0577; tick();
        push = 1'b0; tick(); tick();
        chk("filt_rx",    32'(rx_cnt),   2);
        chk("filt_filt",  32'(filt_cnt), 1);
        chk("filt_level", 32'(level),    2);
        rd_ready = 1'b1;
        chk("rd0", 32'(rd_data), 32'h03AB);
        tick();
        chk("rd1", 32'(rd_data), 32'hFF12);
        tick();
        chk("rd_empty", 32'(rd_valid), 0);
        tick();
        chk("rd_empty_lvl", 32'(level), 0);
        rd_ready = 1'b0;

        // Ten matching pushes into an 8-deep FIFO with no reads.
        for (int i = 0; i < 10; i++) begin
            push = 1'b1; D_push = 16'h0300 + 16'(i); tick();
        end
        push = 1'b0; tick(); tick();
        chk("ovf_level", 32'(level),    8);
        chk("ovf_full",  32'(full),     1);
        chk("ovf_drop",  32'(drop_cnt), 2);
        chk("ovf_rx",    32'(rx_cnt),   10);

        // Push and pop together on a full FIFO: the push is accepted.
        chk("ff_head", 32'(rd_data), 32'h0300);
        push = 1'b1; D_push = 16'h0399; rd_ready = 1'b1;
        tick();
        push = 1'b0;
        chk("ff_level", 32'(level), 8);
        chk("ff_full",  32'(full),  1);
        for (int k = 0; k < 8; k++) begin
            want = (k == 7) ? 16'h0399 : 16'h0301 + 16'(k);
            chk($sformatf("ff_rd%0d", k), 32'(rd_data), 32'(want));
            tick();
        end
        rd_ready = 1'b0;
        chk("ff_empty", 32'(rd_valid), 0);
        chk("ff_drop",  32'(drop_cnt), 2);
        chk("ff_rx",    32'(rx_cnt),   11);

        // Clear, then stream 20 packets at one per cycle while reading.
        reset = 1'b1; tick(); reset = 1'b0;
        chk("rst2_drop", 32'(drop_cnt), 0);
        rd_ready = 1'b1;
        rcv = 0;
        for (int i = 0; i < 24; i++) begin
            if (i < 20) begin
                push   = 1'b1;
                D_push = {((i % 2) == 0) ? 8'h03 : 8'hFF, 8'(8'h40 + i)};
                exp_q.push_back(D_push);
            end else begin
                push = 1'b0;
            end
            if (rd_valid) begin
                want = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
                chk($sformatf("wrap_rd%0d", rcv), 32'(rd_data), 32'(want));
                rcv++;
            end
            tick();
            chk($sformatf("wrap_lvl%0d", i), 32'(level <= 4'd1), 1);
        end
        rd_ready = 1'b0;
        tick();
        chk("wrap_count", 32'(rcv),      20);
        chk("wrap_drop",  32'(drop_cnt), 0);
        chk("wrap_rx_sat", 32'(rx_cnt),  15);

        // Seventeen foreign-ID pushes saturate the 4-bit filter counter.
        for (int i = 0; i < 17; i++) begin
            push = 1'b1; D_push = 16'h0577; tick();
        end
        push = 1'b0; tick(); tick();
        chk("sat_filt",  32'(filt_cnt), 15);
        chk("sat_level", 32'(level),    0);
        chk("sat_drop",  32'(drop_cnt), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
